// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative restoring divider: default width,
// FSM encoding and iteration-count constants.
package div_unit_pkg;

   localparam int DIV_WIDTH  = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } div_state_t;

   // Counter value on which the final restoring step is taken.
   function automatic logic [CNT_W-1:0] last_iter();
      return CNT_W'(ITER_COUNT - 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor over WIDTH+1 bits, keep or restore.
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic             w_carry;
   logic [WIDTH-1:0] w_low;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   // The bit shifted out of rem is the WIDTH+1'th bit of the shifted value;
   // when set, the shifted value always exceeds the divisor.
   assign w_carry = i_rem[WIDTH-1];
   assign w_low   = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
   assign w_diff  = {1'b0, w_low} - {1'b0, i_div};
   assign w_ge    = w_carry | ~w_diff[WIDTH];

   assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_low;
   assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit with start/busy/done handshake.
// Optional divide-by-zero fast path and DZ flag: define DIV_ZERO_DETECT_EN.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
`ifdef DIV_ZERO_DETECT_EN
   output logic             DZ,
`endif
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] HI
);

   div_state_t       r_state;
   div_state_t       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_done;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_quo;
   logic [WIDTH-1:0] w_lo_fix;
   logic [WIDTH-1:0] w_hi_fix;
   logic             w_skip_run;
   logic             w_capture;
   logic             w_step;
   logic             w_fix;

   assign w_a_neg = SIGNED & A[WIDTH-1];
   assign w_b_neg = SIGNED & B[WIDTH-1];
   assign w_a_abs = w_a_neg ? (~A + WIDTH'(1'b1)) : A;
   assign w_b_abs = w_b_neg ? (~B + WIDTH'(1'b1)) : B;

`ifdef DIV_ZERO_DETECT_EN
   logic r_dz_pend;
   logic r_dz;
   assign w_skip_run = (B == {WIDTH{1'b0}});
`else
   assign w_skip_run = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_step_rem),
      .o_quo (w_step_quo)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; START is only honoured in IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_next = w_skip_run ? S_FIX : S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_cnt == last_iter()) begin
               w_next = S_FIX;
            end else begin
               w_next = S_RUN;
            end
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      w_capture = 1'b0;
      w_step    = 1'b0;
      w_fix     = 1'b0;
      case (r_state)
         S_IDLE:  w_capture = START;
         S_RUN:   w_step    = 1'b1;
         S_FIX:   w_fix     = 1'b1;
         default: w_capture = 1'b0;
      endcase
   end

   // Sign correction; remainder follows the dividend's sign.
   always_comb begin
      w_lo_fix = r_neg_q ? (~r_quo + WIDTH'(1'b1)) : r_quo;
      w_hi_fix = r_neg_r ? (~r_rem + WIDTH'(1'b1)) : r_rem;
`ifdef DIV_ZERO_DETECT_EN
      if (r_dz_pend) begin
         w_lo_fix = {WIDTH{1'b0}};
      end else begin
         w_lo_fix = r_neg_q ? (~r_quo + WIDTH'(1'b1)) : r_quo;
      end
`endif
   end

   // Operand capture, iteration, and result registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_rem   <= {WIDTH{1'b0}};
         r_quo   <= {WIDTH{1'b0}};
         r_div   <= {WIDTH{1'b0}};
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_lo    <= {WIDTH{1'b0}};
         r_hi    <= {WIDTH{1'b0}};
         r_done  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         r_dz_pend <= 1'b0;
         r_dz      <= 1'b0;
`endif
      end else begin
         if (w_capture) begin
            // On the zero-divisor fast path |A| goes straight to rem so the
            // sign fix-up reproduces A on HI.
            r_rem   <= w_skip_run ? w_a_abs : {WIDTH{1'b0}};
            r_quo   <= w_a_abs;
            r_div   <= w_b_abs;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= {CNT_W{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
            r_dz_pend <= w_skip_run;
`endif
         end else if (w_step) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + CNT_W'(1'b1);
         end
         r_done <= w_fix;
         if (w_fix) begin
            r_lo <= w_lo_fix;
            r_hi <= w_hi_fix;
`ifdef DIV_ZERO_DETECT_EN
            r_dz <= r_dz_pend;
`endif
         end
      end
   end

   assign BUSY = (r_state != S_IDLE);
   assign DONE = r_done;
   assign LO   = r_lo;
   assign HI   = r_hi;
`ifdef DIV_ZERO_DETECT_EN
   assign DZ   = r_dz;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results with the
// cycle DONE must appear in; a negedge monitor pops and compares.
module tb_div_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic        SIGNED;
   logic [31:0] A;
   logic [31:0] B;
   logic        BUSY;
   logic        DONE;
   logic [31:0] LO;
   logic [31:0] HI;
`ifdef DIV_ZERO_DETECT_EN
   logic        DZ;
   localparam int          ZLAT = 2;
   localparam logic        ZDZ  = 1'b1;
   localparam logic [31:0] ZLO_POS = 32'h0000_0000;
   localparam logic [31:0] ZLO_NEG = 32'h0000_0000;
`else
   localparam int          ZLAT = 34;
   localparam logic        ZDZ  = 1'b0;
   localparam logic [31:0] ZLO_POS = 32'hFFFF_FFFF;
   localparam logic [31:0] ZLO_NEG = 32'h0000_0001;
`endif

   div_unit dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .SIGNED (SIGNED),
      .A      (A),
      .B      (B),
      .BUSY   (BUSY),
      .DONE   (DONE),
`ifdef DIV_ZERO_DETECT_EN
      .DZ     (DZ),
`endif
      .LO     (LO),
      .HI     (HI)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic edz, input int lat);
      exp_t e;
      SIGNED = s;
      A      = a;
      B      = b;
      START  = 1'b1;
      e.lo   = elo;
      e.hi   = ehi;
      e.dz   = edz;
      e.cyc  = cyc + lat;
      sb.push_back(e);
      tick();
      START  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every DONE must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!RESET && DONE) begin
         check("busy_done_excl", {31'b0, BUSY}, 32'h0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: DONE at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("lo", LO, mon_e.lo);
            check("hi", HI, mon_e.hi);
            check("done_cycle", cyc, mon_e.cyc);
`ifdef DIV_ZERO_DETECT_EN
            check("dz", {31'b0, DZ}, {31'b0, mon_e.dz});
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s;
      int n;
      vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
      vecs[1] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0, 34};
      vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 34};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34};
      vecs[4] = '{1'b0, 32'h1234_5678, 32'h0000_0000, ZLO_POS,       32'h1234_5678, ZDZ, ZLAT};
      vecs[5] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_0000, ZLO_NEG,       32'hFFFF_FFF8, ZDZ, ZLAT};
      vecs[6] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34};

      RESET  = 1'b1;
      START  = 1'b0;
      SIGNED = 1'b0;
      A      = 32'h0;
      B      = 32'h0;
      repeat (3) tick();
      check("reset_busy", {31'b0, BUSY}, 32'h0);
      check("reset_done", {31'b0, DONE}, 32'h0);
      check("reset_lo", LO, 32'h0);
      check("reset_hi", HI, 32'h0);
`ifdef DIV_ZERO_DETECT_EN
      check("reset_dz", {31'b0, DZ}, 32'h0);
`endif
      RESET = 1'b0;
      tick();

      // Unsigned 100/7 with BUSY window checks.
      check("idle_busy_c0", {31'b0, BUSY}, 32'h0);
      issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      check("busy_c1", {31'b0, BUSY}, 32'h1);
      repeat (32) tick();
      check("busy_c33", {31'b0, BUSY}, 32'h1);
      tick();
      check("busy_c34", {31'b0, BUSY}, 32'h0);
      check("done_c34", {31'b0, DONE}, 32'h1);
      wait_idle();

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].lat);
         wait_idle();
      end

      // START while busy is dropped; START in the DONE cycle is taken.
      issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);
      repeat (4) tick();
      SIGNED = 1'b1;
      A      = 32'd5;
      B      = 32'd1;
      START  = 1'b1;
      tick();
      START  = 1'b0;
      n = 0;
      while (DONE !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("done_seen", {31'b0, DONE}, 32'h1);
      issue(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 34);
      wait_idle();

      // Reset in cycle 10 of an operation abandons it.
      s      = cyc;
      SIGNED = 1'b0;
      A      = 32'd999;
      B      = 32'd4;
      START  = 1'b1;
      tick();
      START  = 1'b0;
      repeat (9) tick();
      check("abort_at_c10", cyc - s, 32'd10);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("abort_busy", {31'b0, BUSY}, 32'h0);
      check("abort_lo", LO, 32'h0);
      check("abort_hi", HI, 32'h0);
      issue(1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0, 34);
      wait_idle();
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
